// File: rtl/matrix_row_streamer_pkg.sv
// Shared definitions for the matrix row streamer slice.
// Contents:
//   streamer_state_t - top-level FSM states (IDLE, RUN, DONE)
//   row_addr_width() - row address width, never narrower than one bit
//   row_size()       - bits in one memory row (NUM_COLS scalars)
//   cnt_width()      - width of a counter that must hold 0..max_val
package stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } streamer_state_t;

  // A single-row memory still needs a one-bit address port.
  function automatic int row_addr_width(input int num_rows);
    return (num_rows > 1) ? $clog2(num_rows) : 1;
  endfunction

  function automatic int row_size(input int num_cols, input int width);
    return num_cols * width;
  endfunction

  function automatic int cnt_width(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/matrix_row_streamer_if.sv
// Element stream bus driven by matrix_row_streamer.
// Signals:
//   ds_next_data - consumer ready; a transfer happens when ds_valid && ds_next_data
//   ds_out       - WIDTH-bit element, stable while ds_valid waits for ready
//   ds_valid     - ds_out carries an element
// Modports: master (streamer side), slave (consumer side).
interface matrix_row_streamer_if #(
  parameter int WIDTH = 32
) ();

  logic             ds_next_data;
  logic [WIDTH-1:0] ds_out;
  logic             ds_valid;

  modport master (
    input  ds_next_data,
    output ds_out,
    output ds_valid
  );

  modport slave (
    output ds_next_data,
    input  ds_out,
    input  ds_valid
  );

endinterface

// File: rtl/counter_mod.sv
// Up-counter shared across the datapath blocks.
// Counts 0..MAX_VAL on inc, returning to 0 on the increment at MAX_VAL.
// Ports:
//   clk, rst - clock and synchronous active-high reset
//   clr      - synchronous clear (end-of-run housekeeping)
//   inc      - advance by one
//   count    - current value
module counter_mod
  import stream_pkg::*;
#(
  parameter int  MAX_VAL = 1,
  localparam int W       = cnt_width(MAX_VAL)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= (count == W'(MAX_VAL)) ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/row_pingpong_buffer.sv
// Two-slot row buffer: one slot is drained element by element while the
// other receives the next row from memory.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   clr       - empty both slots and rewind the pointers
//   fill      - write fill_data into slot wr_slot, mark it full
//   fill_data - one complete row, column c at [c*WIDTH +: WIDTH]
//   free      - mark slot rd_slot empty and move to the other slot
//   col       - column selected from the read slot
//   full_cnt  - number of full slots (registered state)
//   rd_full   - read slot holds a row
//   rd_data   - selected column of the read slot, 0 when it is empty
module row_pingpong_buffer
  import stream_pkg::*;
#(
  parameter int  WIDTH    = 32,
  parameter int  NUM_COLS = 5,
  localparam int ROW_SIZE = row_size(NUM_COLS, WIDTH),
  localparam int COL_W    = cnt_width(NUM_COLS - 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                fill,
  input  logic [ROW_SIZE-1:0] fill_data,
  input  logic                free,
  input  logic [COL_W-1:0]    col,
  output logic [1:0]          full_cnt,
  output logic                rd_full,
  output logic [WIDTH-1:0]    rd_data
);

  logic [ROW_SIZE-1:0] slot [2];
  logic [ROW_SIZE-1:0] rd_row;
  logic [1:0]          full;
  logic                wr_slot;
  logic                rd_slot;

  // Fill and free never target the same slot: fill needs wr_slot empty,
  // free needs rd_slot full, so both may be applied in one cycle.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      full    <= '0;
      wr_slot <= 1'b0;
      rd_slot <= 1'b0;
    end else begin
      if (fill) begin
        full[wr_slot] <= 1'b1;
        wr_slot       <= ~wr_slot;
      end
      if (free) begin
        full[rd_slot] <= 1'b0;
        rd_slot       <= ~rd_slot;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      slot[wr_slot] <= fill_data;
    end
  end

  assign rd_row   = slot[rd_slot];
  assign rd_full  = full[rd_slot];
  assign full_cnt = {1'b0, full[0]} + {1'b0, full[1]};

  always_comb begin
    rd_data = '0;
    if (rd_full) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        if (col == COL_W'(c)) begin
          rd_data = rd_row[c*WIDTH +: WIDTH];
        end
      end
    end
  end

endmodule

// File: rtl/matrix_row_streamer.sv
// Streams a row-addressable matrix memory as WIDTH-bit elements in
// row-major order, prefetching the next row into a ping-pong buffer
// while the current one drains.
// Ports:
//   clk, rst       - clock and synchronous active-high reset
//   start          - begin a run (only looked at in IDLE)
//   finished       - one-cycle pulse after the last element transfers
//   row_addr       - memory row address, valid with row_addr_ready
//   row_addr_ready - one-cycle read request per row
//   row_valid      - row_out carries the requested row
//   row_out        - row data, column c at [c*WIDTH +: WIDTH]
//   ds             - element stream (master side)
module matrix_row_streamer
  import stream_pkg::*;
#(
  parameter int  NUM_ROWS       = 5,
  parameter int  NUM_COLS       = 5,
  parameter int  WIDTH          = 32,
  parameter int  MEMORY_LATENCY = 2,
  localparam int ROW_ADDR_WIDTH = row_addr_width(NUM_ROWS),
  localparam int ROW_SIZE       = row_size(NUM_COLS, WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      finished,
  output logic [ROW_ADDR_WIDTH-1:0] row_addr,
  output logic                      row_addr_ready,
  input  logic                      row_valid,
  input  logic [ROW_SIZE-1:0]       row_out,
  matrix_row_streamer_if.master     ds
);

  localparam int REQ_W  = cnt_width(NUM_ROWS);
  localparam int COL_W  = cnt_width(NUM_COLS - 1);
  localparam int SENT_W = cnt_width(NUM_ROWS - 1);

  // A request is only recognised as outstanding from the cycle after it
  // issues, so a zero-latency memory would be missed.
  if (MEMORY_LATENCY < 1) begin : g_latency_check
    $error("matrix_row_streamer: MEMORY_LATENCY must be at least 1");
  end

  streamer_state_t   state;
  streamer_state_t   state_next;
  logic              run;
  logic              done_clr;
  logic              outstanding;
  logic              req_go;
  logic              fill;
  logic              xfer;
  logic              free;
  logic              last_xfer;
  logic              rd_full;
  logic [1:0]        full_cnt;
  logic [WIDTH-1:0]  rd_data;
  logic [REQ_W-1:0]  req_row;
  logic [COL_W-1:0]  col;
  logic [SENT_W-1:0] sent_rows;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    finished   = 1'b0;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN:  if (last_xfer) state_next = DONE;
      DONE: begin
        finished   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign run      = (state == RUN);
  assign done_clr = (state == DONE);

  // Request decision uses only registered state: a slot freed this cycle
  // is not counted, and with no request outstanding the occupancy limit
  // reduces to fewer than two full slots.
  assign req_go = run && !outstanding &&
                  (req_row < REQ_W'(NUM_ROWS)) &&
                  (full_cnt < 2'd2);

  assign row_addr_ready = req_go;
  assign row_addr       = req_go ? req_row[ROW_ADDR_WIDTH-1:0] : '0;

  // Returned data without a pending request (idle, or after a reset that
  // dropped the request) is discarded here.
  assign fill = run && outstanding && row_valid;

  always_ff @(posedge clk) begin
    if (rst || done_clr) begin
      outstanding <= 1'b0;
    end else if (req_go) begin
      outstanding <= 1'b1;
    end else if (fill) begin
      outstanding <= 1'b0;
    end
  end

  assign ds.ds_valid = run && rd_full;
  assign ds.ds_out   = run ? rd_data : '0;

  assign xfer      = ds.ds_valid && ds.ds_next_data;
  assign free      = xfer && (col == COL_W'(NUM_COLS - 1));
  assign last_xfer = free && (sent_rows == SENT_W'(NUM_ROWS - 1));

  counter_mod #(.MAX_VAL(NUM_ROWS)) u_req_row (
    .clk   (clk),
    .rst   (rst),
    .clr   (done_clr),
    .inc   (req_go),
    .count (req_row)
  );

  counter_mod #(.MAX_VAL(NUM_COLS - 1)) u_col (
    .clk   (clk),
    .rst   (rst),
    .clr   (done_clr),
    .inc   (xfer),
    .count (col)
  );

  counter_mod #(.MAX_VAL(NUM_ROWS - 1)) u_sent_rows (
    .clk   (clk),
    .rst   (rst),
    .clr   (done_clr),
    .inc   (free),
    .count (sent_rows)
  );

  row_pingpong_buffer #(
    .WIDTH    (WIDTH),
    .NUM_COLS (NUM_COLS)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .clr       (done_clr),
    .fill      (fill),
    .fill_data (row_out),
    .free      (free),
    .col       (col),
    .full_cnt  (full_cnt),
    .rd_full   (rd_full),
    .rd_data   (rd_data)
  );

endmodule
